// File: rtl/mem_access.sv
// MEM-stage data memory access unit: turns a load/store from the pipeline
// into a single registered bus transaction, stalls the pipeline while the
// bus is busy, and returns aligned, extended load data once the bus acks.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  SizeM,
  input  logic        IsUnsignedM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic        HoldM,
  output logic        MemReq,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemBE,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic [31:0] ReadDataM,
  output logic [3:0]  BEOutM,
  output logic        StallM,
  output logic        AddrErrM,
  output logic        BusErrM
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, nextState;
  logic        access;
  logic        misaligned;
  logic        startReq;
  logic        timeout;
  logic [3:0]  beCur;
  logic [31:0] wdRep;
  logic [31:0] readReg;
  logic [7:0]  counter;
  logic [1:0]  sizeReg;
  logic        unsignedReg;
  logic [1:0]  offsetReg;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  assign access     = MemReadM | MemWriteM;
  assign misaligned = ((SizeM == 2'b01) & ALUOutM[0]) |
                      (SizeM[1] & (ALUOutM[1:0] != 2'b00));
  assign startReq   = (state == IDLE) & access & ~misaligned;
  assign timeout    = (counter == 8'hFF) & ~MemAck;
  assign BEOutM     = beCur;
  assign AddrErrM   = (state == IDLE) & access & misaligned;
  assign StallM     = ~rst & (startReq | (state == BUSY));

  // Byte enables and replicated store data for the access presented right now
  always_comb begin
    beCur = 4'b1111;
    wdRep = WriteDataM;
    case (SizeM)
      2'b00: begin
        beCur = 4'b0001 << ALUOutM[1:0];
        wdRep = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        beCur = 4'b0011 << {ALUOutM[1], 1'b0};
        wdRep = {2{WriteDataM[15:0]}};
      end
      default: begin
        beCur = 4'b1111;
        wdRep = WriteDataM;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic: a bus transaction ends on ack or after 256 busy cycles
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (startReq) nextState = BUSY;
      BUSY:    if (MemAck || counter == 8'hFF) nextState = DONE;
      DONE:    if (!HoldM) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Bus registers, timeout counter, read capture and the bus-error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MemReq      <= 1'b0;
      MemWE       <= 1'b0;
      MemAddr     <= '0;
      MemBE       <= '0;
      MemWData    <= '0;
      readReg     <= '0;
      counter     <= '0;
      BusErrM     <= 1'b0;
      sizeReg     <= '0;
      unsignedReg <= 1'b0;
      offsetReg   <= '0;
    end else begin
      BusErrM <= 1'b0;
      case (state)
        IDLE: begin
          if (startReq) begin
            MemReq      <= 1'b1;
            MemWE       <= MemWriteM;
            MemAddr     <= {ALUOutM[31:2], 2'b00};
            MemBE       <= beCur;
            MemWData    <= wdRep;
            sizeReg     <= SizeM;
            unsignedReg <= IsUnsignedM;
            offsetReg   <= ALUOutM[1:0];
            counter     <= '0;
            readReg     <= '0;
          end
        end
        BUSY: begin
          if (MemAck) begin
            readReg <= MemRData;
            MemReq  <= 1'b0;
            counter <= '0;
          end else if (timeout) begin
            readReg <= '0;
            MemReq  <= 1'b0;
            counter <= '0;
            BusErrM <= 1'b1;
          end else begin
            counter <= counter + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Load data: pick the addressed lane from the captured word and extend it
  always_comb begin
    ReadDataM = '0;
    laneByte  = readReg[{offsetReg, 3'b000} +: 8];
    laneHalf  = offsetReg[1] ? readReg[31:16] : readReg[15:0];
    if (state == DONE && !MemWE) begin
      case (sizeReg)
        2'b00:   ReadDataM = unsignedReg ? {24'd0, laneByte}
                                         : {{24{laneByte[7]}}, laneByte};
        2'b01:   ReadDataM = unsignedReg ? {16'd0, laneHalf}
                                         : {{16{laneHalf[15]}}, laneHalf};
        default: ReadDataM = readReg;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access: drives loads and stores through the
// bus handshake and checks bus outputs and returned data against
// hand-computed values.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemReadM = 1'b0, MemWriteM = 1'b0;
  logic [1:0]  SizeM = 2'b00;
  logic        IsUnsignedM = 1'b0;
  logic [31:0] ALUOutM = '0, WriteDataM = '0;
  logic        HoldM = 1'b0;
  logic        MemReq, MemWE;
  logic [31:0] MemAddr, MemWData;
  logic [3:0]  MemBE;
  logic [31:0] MemRData = '0;
  logic        MemAck = 1'b0;
  logic [31:0] ReadDataM;
  logic [3:0]  BEOutM;
  logic        StallM, AddrErrM, BusErrM;

  int vectorCount = 0;
  int missCount   = 0;

  mem_access dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .SizeM(SizeM),
    .IsUnsignedM(IsUnsignedM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .HoldM(HoldM),
    .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr), .MemBE(MemBE),
    .MemWData(MemWData), .MemRData(MemRData), .MemAck(MemAck),
    .ReadDataM(ReadDataM), .BEOutM(BEOutM), .StallM(StallM),
    .AddrErrM(AddrErrM), .BusErrM(BusErrM)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] sz,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    MemReadM = rd; MemWriteM = wr; SizeM = sz; IsUnsignedM = uns;
    ALUOutM = addr; WriteDataM = wd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    MemReadM = 1'b0; MemWriteM = 1'b0;
  endtask

  // One access that the bus acks on its first busy cycle; leaves FSM in DONE
  task automatic runAcked(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input logic [3:0] expBE,
                          input logic [31:0] expAddr, input logic [31:0] expWData,
                          input logic expWE, input logic [31:0] expData);
    applyStimulus(rd, wr, sz, uns, addr, wd);
    checkOutput({tag, " stall idle"}, {31'd0, StallM}, 32'd1);
    checkOutput({tag, " BEOut"}, {28'd0, BEOutM}, {28'd0, expBE});
    tick();
    idleInputs();
    checkOutput({tag, " req"}, {31'd0, MemReq}, 32'd1);
    checkOutput({tag, " we"}, {31'd0, MemWE}, {31'd0, expWE});
    checkOutput({tag, " be"}, {28'd0, MemBE}, {28'd0, expBE});
    checkOutput({tag, " addr"}, MemAddr, expAddr);
    if (expWE) checkOutput({tag, " wdata"}, MemWData, expWData);
    checkOutput({tag, " busy data"}, ReadDataM, 32'd0);
    MemAck = 1'b1; MemRData = rdata;
    tick();
    MemAck = 1'b0;
    checkOutput({tag, " done req"}, {31'd0, MemReq}, 32'd0);
    checkOutput({tag, " done stall"}, {31'd0, StallM}, 32'd0);
    checkOutput({tag, " data"}, ReadDataM, expData);
  endtask

  initial begin
    $display("[TB] mem_access directed test starting");
    #1;
    checkOutput("reset stall", {31'd0, StallM}, 32'd0);
    checkOutput("reset req", {31'd0, MemReq}, 32'd0);
    checkOutput("reset addr", MemAddr, 32'd0);
    checkOutput("reset be", {28'd0, MemBE}, 32'd0);
    checkOutput("reset buserr", {31'd0, BusErrM}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tick();

    // LB signed from byte 3
    runAcked("LB", 1, 0, 2'b00, 0, 32'h00001003, 0, 32'h80FF1234,
             4'b1000, 32'h00001000, 0, 0, 32'hFFFFFF80);
    tick();
    checkOutput("LB idle data", ReadDataM, 32'd0);

    // LHU upper half
    runAcked("LHU", 1, 0, 2'b01, 1, 32'h00001002, 0, 32'h80FF1234,
             4'b1100, 32'h00001000, 0, 0, 32'h000080FF);
    tick();

    // LH signed upper half
    runAcked("LH", 1, 0, 2'b01, 0, 32'h00001002, 0, 32'h80FF1234,
             4'b1100, 32'h00001000, 0, 0, 32'hFFFF80FF);
    tick();

    // LBU lane 1
    runAcked("LBU", 1, 0, 2'b00, 1, 32'h00001001, 0, 32'h80FF1234,
             4'b0010, 32'h00001000, 0, 0, 32'h00000012);
    tick();

    // SB lane 1, data replicated, no load data
    runAcked("SB", 0, 1, 2'b00, 0, 32'h00002001, 32'h000000AB, 32'h55555555,
             4'b0010, 32'h00002000, 32'hABABABAB, 1, 32'd0);
    tick();

    // SH with read and write both set: treated as store
    runAcked("SH", 1, 1, 2'b01, 0, 32'h00002002, 32'h1234BEEF, 32'h55555555,
             4'b1100, 32'h00002000, 32'hBEEFBEEF, 1, 32'd0);
    tick();

    // LW misaligned
    applyStimulus(1, 0, 2'b10, 0, 32'h00001001, 0);
    checkOutput("LW mis addrerr", {31'd0, AddrErrM}, 32'd1);
    checkOutput("LW mis stall", {31'd0, StallM}, 32'd0);
    tick();
    checkOutput("LW mis req", {31'd0, MemReq}, 32'd0);
    idleInputs();
    #1;
    checkOutput("LW mis clear", {31'd0, AddrErrM}, 32'd0);

    // Stray ack in IDLE is ignored
    MemAck = 1'b1; MemRData = 32'hDEADBEEF;
    tick();
    MemAck = 1'b0;
    checkOutput("stray ack req", {31'd0, MemReq}, 32'd0);
    checkOutput("stray ack data", ReadDataM, 32'd0);

    // LW timeout: 256 busy cycles without ack
    applyStimulus(1, 0, 2'b10, 0, 32'h00003000, 0);
    tick();
    idleInputs();
    repeat (255) tick();
    checkOutput("TO busy stall", {31'd0, StallM}, 32'd1);
    checkOutput("TO busy buserr", {31'd0, BusErrM}, 32'd0);
    tick();
    checkOutput("TO buserr", {31'd0, BusErrM}, 32'd1);
    checkOutput("TO stall", {31'd0, StallM}, 32'd0);
    checkOutput("TO data", ReadDataM, 32'd0);
    checkOutput("TO req", {31'd0, MemReq}, 32'd0);
    tick();
    checkOutput("TO pulse", {31'd0, BusErrM}, 32'd0);

    // LW acked exactly on the last counter value: ack wins
    applyStimulus(1, 0, 2'b10, 0, 32'h00003000, 0);
    tick();
    idleInputs();
    repeat (255) tick();
    MemAck = 1'b1; MemRData = 32'hCAFEF00D;
    tick();
    MemAck = 1'b0;
    checkOutput("late ack buserr", {31'd0, BusErrM}, 32'd0);
    checkOutput("late ack data", ReadDataM, 32'hCAFEF00D);
    tick();

    // Reset pulse mid-BUSY, then a late ack
    applyStimulus(1, 0, 2'b10, 0, 32'h00004000, 0);
    tick();
    idleInputs();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("rst req drop", {31'd0, MemReq}, 32'd0);
    checkOutput("rst stall", {31'd0, StallM}, 32'd0);
    tick();
    rst = 1'b0;
    MemAck = 1'b1; MemRData = 32'h12345678;
    tick();
    MemAck = 1'b0;
    checkOutput("post rst req", {31'd0, MemReq}, 32'd0);
    checkOutput("post rst data", ReadDataM, 32'd0);
    checkOutput("post rst stall", {31'd0, StallM}, 32'd0);

    // DONE held for 3 cycles keeps data stable
    HoldM = 1'b1;
    runAcked("HOLD", 1, 0, 2'b10, 0, 32'h00005000, 0, 32'h0BADF00D,
             4'b1111, 32'h00005000, 0, 0, 32'h0BADF00D);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hold data", ReadDataM, 32'h0BADF00D);
      checkOutput("hold stall", {31'd0, StallM}, 32'd0);
    end
    HoldM = 1'b0;
    tick();
    checkOutput("hold release", ReadDataM, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
